// File: rtl/la_debounce.sv
// Debounce and edge-detect stage for an already-synchronized level.
// A change on 'in' must persist for HOLD enabled cycles before 'out' follows.
module la_debounce #(
  parameter        PROP   = "DEFAULT",
  parameter int    HOLD   = 4,
  parameter bit    RSTVAL = 1'b0,
  parameter int    CW     = $clog2(HOLD + 1)
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= RSTVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Strobes default low so they never stretch across a disabled edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      if (in == out_q) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          STABLE: begin
            if (HOLD == 1) begin
              out_d  = in;
              rise_d = in;
              fall_d = ~in;
            end else begin
              state_d = PEND;
              cnt_d   = CW'(1);
            end
          end
          PEND: begin
            if (cnt_q == CW'(HOLD - 1)) begin
              state_d = STABLE;
              cnt_d   = '0;
              out_d   = in;
              rise_d  = in;
              fall_d  = ~in;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    out  = out_q;
    rise = rise_q;
    fall = fall_q;
    busy = (state_q == PEND);
  end

endmodule
